correlator_sample_sequencer: RTL and testbench
==============================================

# correlator_sample_sequencer

Sequencer for the bipolar probe correlator datapath. Generates the sample strobe that captures `i_x`/`i_y` into the correlator's accumulators, applying a configurable power-of-two sample period plus pseudo-random jitter. Frames samples into power-of-two windows. Hands each completed window to the USB packetiser with a valid/ready handshake. It sits between the USB register interface, which supplies its configuration, and the correlator accumulators plus packet FIFO, which it drives.

## Interface
- `MAX_WINDOW_LENGTH_EXP`, default 16: maximum window length exponent; a window holds 2**w samples.
- `MAX_SAMPLE_PERIOD_EXP`, default 15: maximum sample period exponent; the base period is 2**p cycles.
- `MAX_SAMPLE_JITTER_EXP`, default 8: maximum jitter exponent; jitter is 0..2**j-1 extra cycles.
- `LFSR_SEED`, default 16'hACE1: reset value of the jitter LFSR; must be nonzero.

- `i_clk` in, 1: single clock, 48MHz. One clock; reset is synchronous and active-high.
- `i_rst` in, 1: reset.
- `i_cg` in, 1: clock-gate enable. When low, all state holds and all pulse outputs are 0.
- `i_enable` in, 1: run request.
- `i_windowLengthExp` in, clog2(MAX_WINDOW_LENGTH_EXP+1): w. Values above max clamp to max.
- `i_samplePeriodExp` in, clog2(MAX_SAMPLE_PERIOD_EXP+1): p. Clamped the same way.
- `i_sampleJitterExp` in, clog2(MAX_SAMPLE_JITTER_EXP+1): j. Clamped to min(j, MAX, p).
- `o_sampleStrobe` out, 1: one-cycle capture pulse.
- `o_windowStart` out, 1: coincides with the first strobe of a window; clears the accumulators.
- `o_windowValid` out, 1: window complete; results are stable.
- `i_windowReady` in, 1: the packetiser accepts the window.
- `o_windowSeq` out, 8: count of transferred windows; wraps 255 to 0.
- `o_busy` out, 1: state is not IDLE.

## Operation
- States are IDLE, SAMPLING and DONE. The encoding is 2 bits; 2'b11 is illegal and recovers to IDLE.
- **IDLE, with `i_enable`=1:**
  - Latch clamped w, p and j into config registers.
  - Go to SAMPLING. `o_sampleStrobe` and `o_windowStart` are both 1 in that first SAMPLING cycle.
  - Load `sampleCnt` with 2**w-1.
  - Load `intervalCnt` with 2**p + (lfsr & (2**j-1)) - 1, then step the LFSR.
- **SAMPLING, each enabled cycle:**
  - If `intervalCnt`≠0, decrement it.
  - Otherwise, if `sampleCnt`≠0:
    - strobe;
    - decrement `sampleCnt`;
    - reload `intervalCnt` using the formula above and step the LFSR.
  - Otherwise (`intervalCnt`=0 and `sampleCnt`=0), go to DONE with no strobe.
- **DONE:**
  - `o_windowValid`=1 is held until `i_windowReady`=1. Transfer occurs when valid&&ready.
  - On transfer, `o_windowSeq`++.
  - Next state is SAMPLING if `i_enable`=1, with config relatched and new start strobes in the first cycle. Otherwise the next state is IDLE.
- **`i_enable`=0 in SAMPLING:** abort. Go to IDLE next cycle. No `o_windowValid`, and `o_windowSeq` is unchanged.
- **`i_enable`=0 in DONE:** the pending window is still delivered.
- Config inputs changing mid-window have no effect until the next latch.
- Strobes per window are exactly 2**w. The strobe-to-strobe spacing lies in [2**p, 2**p+2**j-1] cycles.
- The LFSR is 16-bit Galois with polynomial x^16+x^14+x^13+x^11+1. It steps only on interval load.

## Timing
- All outputs are registered. Reset values:
  - state IDLE;
  - all outputs 0, including `o_windowSeq`=0;
  - LFSR = `LFSR_SEED`;
  - counters 0.
- `i_rst` has priority over everything. Reset mid-window gives IDLE in the next cycle with no valid.
- `i_enable` to first strobe takes 1 cycle.
- Last strobe to `o_windowValid` takes 2**p+jitter cycles, i.e. one full interval after the last strobe.
- Ready asserted in the same cycle as valid transfers immediately. The next window's start strobe follows 1 cycle later.
- With `i_cg`=0, everything freezes, including `o_windowValid`. The handshake cannot complete.

## Structure
- `correlatorSeqPkg` holds:
  - the state enum;
  - the width localparams for `sampleCnt` (MAX_WINDOW_LENGTH_EXP+1) and `intervalCnt` (MAX_SAMPLE_PERIOD_EXP+1);
  - the LFSR taps constant.
- One sub-module, `lfsr16_galois`, with ports (`i_clk`, `i_rst`, `i_cg`, `i_step`, `o_value`) and a seed parameter.

## Test plan
- **Basic window:** w=2, p=3, j=0, enable held.
  - Strobes occur at cycles 1, 9, 17, 25; windowStart only at cycle 1.
  - Valid occurs at 33.
  - With ready tied high, the second window starts at 34.
- **Jitter bound:** w=8, p=4, j=3. Over 256 strobes, every gap lies in [16, 23], and at least 4 distinct gap values appear.
- **Backpressure:** ready low for 100 cycles after valid. Valid is held with no strobes; on ready, seq goes 0 to 1 and a new window starts the next cycle.
- **Abort:** deassert enable at strobe 3 of 16. Response is IDLE next cycle, no valid, and seq unchanged.
- **Clamp and wrap:**
  - Inputs w=31 and j>p are treated as MAX_WINDOW_LENGTH_EXP and p respectively.
  - 256 transfers with w=0, p=0 wrap seq to 0.
- **Reset and cg:** i_cg low mid-SAMPLING freezes the counters for 50 cycles, and the gap extends by exactly 50. A reset pulse in DONE clears valid and busy next cycle.

Source files
------------

// File: rtl/correlator_sample_sequencer_pkg.sv
// Shared state encoding, counter widths and LFSR taps for the correlator sample sequencer.
package correlatorSeqPkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SAMPLING = 2'b01,
    DONE     = 2'b10
  } seq_state_t;

  localparam int DEFAULT_MAX_WINDOW_LENGTH_EXP = 16;
  localparam int DEFAULT_MAX_SAMPLE_PERIOD_EXP = 15;
  localparam int DEFAULT_MAX_SAMPLE_JITTER_EXP = 8;

  // Counters are sized for the largest supported exponents; instances may lower the maxima but not raise them.
  localparam int SAMPLE_CNT_W   = DEFAULT_MAX_WINDOW_LENGTH_EXP + 1;
  localparam int INTERVAL_CNT_W = DEFAULT_MAX_SAMPLE_PERIOD_EXP + 1;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/correlator_sample_sequencer_lfsr16_galois.sv
// Jitter source: 16-bit Galois LFSR that advances only when a new sample interval is loaded.
module lfsr16_galois
  import correlatorSeqPkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cg,
  input  logic        i_step,
  output logic [15:0] o_value
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_value <= SEED;
    end else if (i_cg && i_step) begin
      o_value <= (o_value >> 1) ^ (o_value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/correlator_sample_sequencer.sv
// Sample strobe generator with jittered power-of-two spacing, framed into windows
// that are handed to the packetiser over a valid/ready handshake.
module correlator_sample_sequencer
  import correlatorSeqPkg::*;
#(
  parameter int          MAX_WINDOW_LENGTH_EXP = DEFAULT_MAX_WINDOW_LENGTH_EXP,
  parameter int          MAX_SAMPLE_PERIOD_EXP = DEFAULT_MAX_SAMPLE_PERIOD_EXP,
  parameter int          MAX_SAMPLE_JITTER_EXP = DEFAULT_MAX_SAMPLE_JITTER_EXP,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_cg,
  input  logic                                     i_enable,
  input  logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0] i_windowLengthExp,
  input  logic [$clog2(MAX_SAMPLE_PERIOD_EXP+1)-1:0] i_samplePeriodExp,
  input  logic [$clog2(MAX_SAMPLE_JITTER_EXP+1)-1:0] i_sampleJitterExp,
  output logic                                     o_sampleStrobe,
  output logic                                     o_windowStart,
  output logic                                     o_windowValid,
  input  logic                                     i_windowReady,
  output logic [7:0]                               o_windowSeq,
  output logic                                     o_busy
);

  localparam int W_EXP_W = $clog2(MAX_WINDOW_LENGTH_EXP + 1);
  localparam int P_EXP_W = $clog2(MAX_SAMPLE_PERIOD_EXP + 1);
  localparam int J_EXP_W = $clog2(MAX_SAMPLE_JITTER_EXP + 1);

  seq_state_t state, state_next;

  logic [W_EXP_W-1:0]        w_clamp;
  logic [P_EXP_W-1:0]        p_clamp, cfg_p, load_p;
  logic [J_EXP_W-1:0]        j_clamp, cfg_j, load_j;
  logic [SAMPLE_CNT_W-1:0]   sample_cnt, sample_load;
  logic [INTERVAL_CNT_W-1:0] interval_cnt, interval_load;
  logic [15:0]               lfsr_value;

  logic strobe_next, start_next;
  logic load_window, load_interval, dec_interval, dec_sample, transfer;

  always_comb begin
    w_clamp = i_windowLengthExp;
    if (int'(i_windowLengthExp) > MAX_WINDOW_LENGTH_EXP) w_clamp = W_EXP_W'(MAX_WINDOW_LENGTH_EXP);
    p_clamp = i_samplePeriodExp;
    if (int'(i_samplePeriodExp) > MAX_SAMPLE_PERIOD_EXP) p_clamp = P_EXP_W'(MAX_SAMPLE_PERIOD_EXP);
    j_clamp = i_sampleJitterExp;
    if (int'(i_sampleJitterExp) > MAX_SAMPLE_JITTER_EXP) j_clamp = J_EXP_W'(MAX_SAMPLE_JITTER_EXP);
    if (int'(j_clamp) > int'(p_clamp)) j_clamp = J_EXP_W'(p_clamp);
  end

  // The first interval of a window uses the freshly clamped inputs; later ones use the latched copy.
  assign load_p = load_window ? p_clamp : cfg_p;
  assign load_j = load_window ? j_clamp : cfg_j;

  assign interval_load = INTERVAL_CNT_W'((32'd1 << load_p)
                         + (32'(lfsr_value) & ((32'd1 << load_j) - 32'd1)) - 32'd1);
  assign sample_load   = SAMPLE_CNT_W'((32'd1 << w_clamp) - 32'd1);

  lfsr16_galois #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cg    (i_cg),
    .i_step  (load_interval),
    .o_value (lfsr_value)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else if (i_cg) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    strobe_next   = 1'b0;
    start_next    = 1'b0;
    load_window   = 1'b0;
    load_interval = 1'b0;
    dec_interval  = 1'b0;
    dec_sample    = 1'b0;
    transfer      = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_next    = SAMPLING;
          strobe_next   = 1'b1;
          start_next    = 1'b1;
          load_window   = 1'b1;
          load_interval = 1'b1;
        end
      end
      SAMPLING: begin
        if (!i_enable) begin
          state_next = IDLE;
        end else if (interval_cnt != '0) begin
          dec_interval = 1'b1;
        end else if (sample_cnt != '0) begin
          strobe_next   = 1'b1;
          dec_sample    = 1'b1;
          load_interval = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        transfer = o_windowValid && i_windowReady;
        if (transfer) begin
          if (i_enable) begin
            state_next    = SAMPLING;
            strobe_next   = 1'b1;
            start_next    = 1'b1;
            load_window   = 1'b1;
            load_interval = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // With the clock gate low every register holds except the one-cycle pulses, which drop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sampleStrobe <= 1'b0;
      o_windowStart  <= 1'b0;
      o_windowValid  <= 1'b0;
      o_busy         <= 1'b0;
      o_windowSeq    <= 8'd0;
      sample_cnt     <= '0;
      interval_cnt   <= '0;
      cfg_p          <= '0;
      cfg_j          <= '0;
    end else if (!i_cg) begin
      o_sampleStrobe <= 1'b0;
      o_windowStart  <= 1'b0;
    end else begin
      o_sampleStrobe <= strobe_next;
      o_windowStart  <= start_next;
      o_windowValid  <= (state_next == DONE);
      o_busy         <= (state_next != IDLE);
      if (load_window) begin
        cfg_p      <= p_clamp;
        cfg_j      <= j_clamp;
        sample_cnt <= sample_load;
      end else if (dec_sample) begin
        sample_cnt <= sample_cnt - SAMPLE_CNT_W'(1);
      end
      if (load_interval) begin
        interval_cnt <= interval_load;
      end else if (dec_interval) begin
        interval_cnt <= interval_cnt - INTERVAL_CNT_W'(1);
      end
      if (transfer) begin
        o_windowSeq <= o_windowSeq + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_correlator_sample_sequencer.sv
// Self-checking bench: predicts strobe/valid cycle timelines from the sampling rules
// and compares every cycle's outputs against them.
module tb_correlator_sample_sequencer;

  localparam int          MAX_W = 16;
  localparam int          MAX_P = 15;
  localparam int          MAX_J = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst, cg, enable, ready;
  logic [4:0] w_exp;
  logic [3:0] p_exp, j_exp;
  logic       strobe, start, valid, busy;
  logic [7:0] seq;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_strobes[$];
  int          exp_valid;
  logic [15:0] m_lfsr;
  int          m_seq;

  always #5 clk = ~clk;

  correlator_sample_sequencer #(
    .MAX_WINDOW_LENGTH_EXP (MAX_W),
    .MAX_SAMPLE_PERIOD_EXP (MAX_P),
    .MAX_SAMPLE_JITTER_EXP (MAX_J),
    .LFSR_SEED             (SEED)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_cg              (cg),
    .i_enable          (enable),
    .i_windowLengthExp (w_exp),
    .i_samplePeriodExp (p_exp),
    .i_sampleJitterExp (j_exp),
    .o_sampleStrobe    (strobe),
    .o_windowStart     (start),
    .o_windowValid     (valid),
    .i_windowReady     (ready),
    .o_windowSeq       (seq),
    .o_busy            (busy)
  );

  // Feedback mask built from the polynomial exponents rather than a hex constant.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] fb;
    int          exps[4];
    exps = '{16, 14, 13, 11};
    fb = 16'h0000;
    foreach (exps[i]) fb[exps[i]-1] = 1'b1;
    return v[0] ? ((v >> 1) ^ fb) : (v >> 1);
  endfunction

  task automatic draw_gap(input int p, input int j, output int gap);
    gap = (1 << p) + (int'(m_lfsr) % (1 << j));
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  // One window: 2**w strobes starting at cycle t0, each followed by one jittered interval; valid after the last.
  task automatic model_window(input int w_in, input int p_in, input int j_in, input int t0);
    int w, p, j, gap, t;
    w = (w_in > MAX_W) ? MAX_W : w_in;
    p = (p_in > MAX_P) ? MAX_P : p_in;
    j = (j_in > MAX_J) ? MAX_J : j_in;
    if (j > p) j = p;
    exp_strobes.delete();
    t = t0;
    for (int n = 0; n < (1 << w); n++) begin
      exp_strobes.push_back(t);
      draw_gap(p, j, gap);
      t += gap;
    end
    exp_valid = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cg = 1'b1; enable = 1'b0; ready = 1'b0;
    w_exp = '0; p_exp = '0; j_exp = '0;
    tick();
    tick();
    rst = 1'b0;
    m_lfsr = SEED;
    m_seq = 0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1; cg = 1'b1; enable = 1'b1; ready = 1'b1;
    w_exp = 5'd2; p_exp = 4'd1; j_exp = 4'd0;
    for (int c = 0; c < 2; c++) begin
      tick();
      got = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== 12'h000) begin
        n_fail++;
        $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", c, got, 12'h000);
      end
    end
    rst = 1'b0; enable = 1'b0;
    tick();
    got = {strobe, start, valid, busy, seq};
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got %h expected %h", got, 12'h000);
    end
  endtask

  task automatic test_basic_window();
    logic [11:0] got, want;
    logic        s_exp;
    int          k;
    do_reset();
    w_exp = 5'd2; p_exp = 4'd3; j_exp = 4'd0; ready = 1'b1; enable = 1'b1;
    model_window(2, 3, 0, 1);
    k = 0;
    for (int c = 1; c <= exp_valid; c++) begin
      tick();
      s_exp = (k < exp_strobes.size()) && (exp_strobes[k] == c);
      if (s_exp) k++;
      want = {s_exp, c == exp_strobes[0], c == exp_valid, 1'b1, 8'(m_seq)};
      got  = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL basic_window cycle %0d: got %h expected %h", c, got, want);
      end
    end
    m_seq++;
    tick();
    want = {1'b1, 1'b1, 1'b0, 1'b1, 8'(m_seq)};
    got  = {strobe, start, valid, busy, seq};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL basic_next_window_start: got %h expected %h", got, want);
    end
    enable = 1'b0;
    tick();
    want = {4'b0000, 8'(m_seq)};
    got  = {strobe, start, valid, busy, seq};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL basic_abort_idle: got %h expected %h", got, want);
    end
  endtask

  task automatic test_jitter_bound();
    logic [11:0] got, want;
    logic        s_exp;
    int          k, last, g;
    bit          seen[int];
    do_reset();
    w_exp = 5'd8; p_exp = 4'd4; j_exp = 4'd3; ready = 1'b0; enable = 1'b1;
    model_window(8, 4, 3, 1);
    k = 0;
    last = -1;
    for (int c = 1; c <= exp_valid; c++) begin
      tick();
      s_exp = (k < exp_strobes.size()) && (exp_strobes[k] == c);
      if (s_exp) k++;
      want = {s_exp, c == exp_strobes[0], c == exp_valid, 1'b1, 8'(m_seq)};
      got  = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL jitter_window cycle %0d: got %h expected %h", c, got, want);
      end
      if (strobe === 1'b1) begin
        if (last >= 0) begin
          g = c - last;
          seen[g] = 1'b1;
          n_checks++;
          if (g < 16 || g > 23) begin
            n_fail++;
            $display("[TB] FAIL jitter_gap cycle %0d: got %0d expected 16..23", c, g);
          end
        end
        last = c;
      end
      // Scribbling on the config inputs mid-window must not disturb the latched window.
      w_exp = 5'($urandom_range(0, 31));
      p_exp = 4'($urandom_range(0, 15));
      j_exp = 4'($urandom_range(0, 15));
    end
    n_checks++;
    if (seen.num() < 4) begin
      n_fail++;
      $display("[TB] FAIL jitter_distinct: got %0d distinct gaps expected at least 4", seen.num());
    end
    enable = 1'b0; ready = 1'b1;
    tick();
    m_seq++;
    want = {4'b0000, 8'(m_seq)};
    got  = {strobe, start, valid, busy, seq};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL jitter_deliver_while_disabled: got %h expected %h", got, want);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] got, want;
    logic        s_exp;
    int          k, w, p, j;
    do_reset();
    w = $urandom_range(0, 2); p = $urandom_range(1, 3); j = $urandom_range(0, 3);
    w_exp = 5'(w); p_exp = 4'(p); j_exp = 4'(j); ready = 1'b0; enable = 1'b1;
    model_window(w, p, j, 1);
    k = 0;
    for (int c = 1; c <= exp_valid + 100; c++) begin
      tick();
      s_exp = (k < exp_strobes.size()) && (exp_strobes[k] == c);
      if (s_exp) k++;
      want = {s_exp, c == exp_strobes[0], c >= exp_valid, 1'b1, 8'(m_seq)};
      got  = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL backpressure cycle %0d: got %h expected %h", c, got, want);
      end
    end
    ready = 1'b1;
    tick();
    m_seq++;
    want = {1'b1, 1'b1, 1'b0, 1'b1, 8'(m_seq)};
    got  = {strobe, start, valid, busy, seq};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL backpressure_release: got %h expected %h", got, want);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic [11:0] got, want;
    logic        s_exp;
    int          k, p, j;
    do_reset();
    p = $urandom_range(1, 3); j = $urandom_range(0, p);
    w_exp = 5'd4; p_exp = 4'(p); j_exp = 4'(j); ready = 1'b1; enable = 1'b1;
    model_window(4, p, j, 1);
    k = 0;
    for (int c = 1; c <= exp_strobes[2]; c++) begin
      tick();
      s_exp = (k < exp_strobes.size()) && (exp_strobes[k] == c);
      if (s_exp) k++;
      want = {s_exp, c == exp_strobes[0], 1'b0, 1'b1, 8'(m_seq)};
      got  = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL abort_window cycle %0d: got %h expected %h", c, got, want);
      end
    end
    enable = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      want = {4'b0000, 8'(m_seq)};
      got  = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL abort_idle cycle %0d: got %h expected %h", c, got, want);
      end
    end
  endtask

  task automatic test_clamp();
    logic [11:0] got, want;
    logic        s_exp;
    int          k, p, j, t0;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        p = 0; j = $urandom_range(1, 15);
        w_exp = 5'd31;
      end else begin
        p = $urandom_range(1, 4); j = $urandom_range(p + 1, 15);
        w_exp = 5'd3;
      end
      p_exp = 4'(p); j_exp = 4'(j); ready = 1'b0; enable = 1'b1;
      t0 = 1;
      model_window(int'(w_exp), p, j, t0);
      k = 0;
      for (int c = t0; c <= exp_valid; c++) begin
        tick();
        s_exp = (k < exp_strobes.size()) && (exp_strobes[k] == c);
        if (s_exp) k++;
        want = {s_exp, c == exp_strobes[0], c == exp_valid, 1'b1, 8'(m_seq)};
        got  = {strobe, start, valid, busy, seq};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("[TB] FAIL clamp_pass%0d cycle %0d: got %h expected %h", pass, c, got, want);
        end
      end
      enable = 1'b0; ready = 1'b1;
      tick();
      m_seq++;
      want = {4'b0000, 8'(m_seq)};
      got  = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL clamp_pass%0d_done: got %h expected %h", pass, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] got, want;
    logic        s_exp;
    int          k, t0;
    do_reset();
    w_exp = 5'd0; p_exp = 4'd0; j_exp = 4'd0; ready = 1'b1; enable = 1'b1;
    t0 = 1;
    for (int n = 0; n < 256; n++) begin
      model_window(0, 0, 0, t0);
      k = 0;
      for (int c = t0; c <= exp_valid; c++) begin
        tick();
        s_exp = (k < exp_strobes.size()) && (exp_strobes[k] == c);
        if (s_exp) k++;
        want = {s_exp, c == exp_strobes[0], c == exp_valid, 1'b1, 8'(m_seq)};
        got  = {strobe, start, valid, busy, seq};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("[TB] FAIL wrap window %0d cycle %0d: got %h expected %h", n, c, got, want);
        end
      end
      m_seq++;
      if (n == 255) enable = 1'b0;
      t0 = exp_valid + 1;
    end
    tick();
    want = {4'b0000, 8'(m_seq)};
    got  = {strobe, start, valid, busy, seq};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL wrap_final: got %h expected %h", got, want);
    end
  endtask

  task automatic test_cg_and_reset();
    logic [11:0] got, want;
    logic        s_exp;
    int          k, j, freeze_at, base_gap, first_seen, second_seen;
    do_reset();
    j = $urandom_range(0, 4);
    w_exp = 5'd2; p_exp = 4'd4; j_exp = 4'(j); ready = 1'b0; enable = 1'b1;
    model_window(2, 4, j, 1);
    base_gap = exp_strobes[1] - exp_strobes[0];
    freeze_at = exp_strobes[0] + 3;
    foreach (exp_strobes[i]) if (exp_strobes[i] > freeze_at) exp_strobes[i] += 50;
    exp_valid += 50;
    k = 0;
    first_seen = -1;
    second_seen = -1;
    for (int c = 1; c <= exp_valid; c++) begin
      tick();
      s_exp = (k < exp_strobes.size()) && (exp_strobes[k] == c);
      if (s_exp) k++;
      want = {s_exp, c == exp_strobes[0], c == exp_valid, 1'b1, 8'(m_seq)};
      got  = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL cg_window cycle %0d: got %h expected %h", c, got, want);
      end
      if (strobe === 1'b1) begin
        if (first_seen < 0) first_seen = c;
        else if (second_seen < 0) second_seen = c;
      end
      if (c == freeze_at) cg = 1'b0;
      if (c == freeze_at + 50) cg = 1'b1;
    end
    n_checks++;
    if (second_seen - first_seen != base_gap + 50) begin
      n_fail++;
      $display("[TB] FAIL cg_gap_extension: got %0d expected %0d", second_seen - first_seen, base_gap + 50);
    end
    cg = 1'b0; ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      want = {1'b0, 1'b0, 1'b1, 1'b1, 8'(m_seq)};
      got  = {strobe, start, valid, busy, seq};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL cg_done_frozen cycle %0d: got %h expected %h", c, got, want);
      end
    end
    cg = 1'b1; ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    want = 12'h000;
    got  = {strobe, start, valid, busy, seq};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL reset_in_done: got %h expected %h", got, want);
    end
  endtask

  initial begin
    rst = 1'b1; cg = 1'b1; enable = 1'b0; ready = 1'b0;
    w_exp = '0; p_exp = '0; j_exp = '0;
    m_lfsr = SEED;
    m_seq = 0;
    test_reset();
    test_basic_window();
    test_jitter_bound();
    test_backpressure();
    test_abort();
    test_clamp();
    test_wrap();
    test_cg_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
